key_sched_ctrl: RTL and testbench

Controller that sequences the pipelined `key_expansion` block and serves its results to the cipher core. It accepts a 256-bit AES key over a valid/ready handshake and holds it stable on the expansion input for a fixed number of cycles. It then captures all 15 round keys into a local store and serves one 128-bit round key per request by index. Sits between the key-load interface and `key_expansion`/cipher rounds; blocks key reloads while the cipher core holds a lock.

---
 rtl/key_sched_ctrl.sv | 125 ++++++++++++
 tb/tb_key_sched_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/key_sched_ctrl.sv
// Sequences key_expansion: latches a 256-bit key, waits for expansion, captures and serves 15 round keys.
// Latency: capture expand_latency_p cycles after key handshake; round-key response one cycle after request.
// Backpressure: key_ready_o low while expanding or while lock_i is high in READY; requests are never stalled.
module key_sched_ctrl #(
    parameter int expand_latency_p = 14,
    parameter int num_keys_p       = 15
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic [0:255]              key_i,
    input  logic                      key_v_i,
    output logic                      key_ready_o,
    output logic [0:255]              exp_key_o,
    input  logic [0:128*num_keys_p-1] exp_round_keys_i,
    input  logic                      lock_i,
    input  logic                      rk_req_v_i,
    input  logic [3:0]                rk_idx_i,
    output logic                      rk_v_o,
    output logic [127:0]              rk_o,
    output logic                      rk_err_o,
    output logic                      key_valid_o,
    output logic                      busy_o
);

    localparam int cnt_w_lp = $clog2(expand_latency_p) + 1;

    // The counter must count at least one cycle and the 4-bit index must reach every stored key.
    if (expand_latency_p < 1) begin : g_bad_latency
        $error("expand_latency_p must be at least 1");
    end
    if (num_keys_p < 1 || num_keys_p > 16) begin : g_bad_num_keys
        $error("num_keys_p must be in 1..16");
    end

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        EXPAND = 2'd1,
        READY  = 2'd2
    } state_e;

    state_e                state_r;
    logic [cnt_w_lp-1:0]   cnt_r;
    logic [127:0]          store_r [num_keys_p];
    logic                  key_hs;
    logic                  idx_ok;

    // A new key is only taken when no expansion is running and the cipher core is not holding the keys.
    assign key_ready_o = (state_r == IDLE) || ((state_r == READY) && !lock_i);
    assign key_hs      = key_v_i && key_ready_o;
    assign idx_ok      = 32'(rk_idx_i) < num_keys_p;

    // Key load / expansion wait / capture sequencing; exp_key_o only moves on a handshake.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r     <= IDLE;
            exp_key_o   <= '0;
            cnt_r       <= '0;
            key_valid_o <= 1'b0;
            busy_o      <= 1'b0;
            for (int n = 0; n < num_keys_p; n++) begin
                store_r[n] <= '0;
            end
        end else begin
            case (state_r)
                IDLE: begin
                    if (key_hs) begin
                        exp_key_o <= key_i;
                        cnt_r     <= cnt_w_lp'(expand_latency_p - 1);
                        busy_o    <= 1'b1;
                        state_r   <= EXPAND;
                    end
                end
                EXPAND: begin
                    // Counter reaching zero marks the edge where key_expansion has settled.
                    if (cnt_r == '0) begin
                        for (int n = 0; n < num_keys_p; n++) begin
                            store_r[n] <= exp_round_keys_i[128*n +: 128];
                        end
                        key_valid_o <= 1'b1;
                        busy_o      <= 1'b0;
                        state_r     <= READY;
                    end else begin
                        cnt_r <= cnt_r - cnt_w_lp'(1);
                    end
                end
                READY: begin
                    // Old keys stay readable during this cycle; they become stale at the edge.
                    if (key_hs) begin
                        exp_key_o   <= key_i;
                        cnt_r       <= cnt_w_lp'(expand_latency_p - 1);
                        key_valid_o <= 1'b0;
                        busy_o      <= 1'b1;
                        state_r     <= EXPAND;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

    // One registered response per request; refused when keys are stale or the index is out of range.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rk_v_o   <= 1'b0;
            rk_err_o <= 1'b0;
            rk_o     <= '0;
        end else if (rk_req_v_i) begin
            if (key_valid_o && idx_ok) begin
                rk_v_o   <= 1'b1;
                rk_err_o <= 1'b0;
                rk_o     <= store_r[rk_idx_i];
            end else begin
                rk_v_o   <= 1'b0;
                rk_err_o <= 1'b1;
                rk_o     <= '0;
            end
        end else begin
            rk_v_o   <= 1'b0;
            rk_err_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_key_sched_ctrl.sv
// Directed bench for key_sched_ctrl with a combinational stand-in for key_expansion.
// Inputs are driven and outputs sampled on the falling clock edge.
// Round-key requests use a vector table; multi-cycle corners are hand-written sequences.
module tb_key_sched_ctrl;

    localparam int L = 14;

    localparam logic [0:255] K64  = {32{8'h64}};
    localparam logic [0:255] KF   = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;
    localparam logic [0:255] KL   = {32{8'h5a}};
    localparam logic [0:255] KA   = {{16{8'h00}}, {16{8'h11}}};
    localparam logic [0:255] KB   = {32{8'hab}};

    logic                 clk;
    logic                 reset;
    logic [0:255]         key;
    logic                 key_v;
    logic                 key_ready;
    logic [0:255]         exp_key;
    logic [0:128*15-1]    exp_rks;
    logic                 lock;
    logic                 rk_req_v;
    logic [3:0]           rk_idx;
    logic                 rk_v;
    logic [127:0]         rk;
    logic                 rk_err;
    logic                 key_valid;
    logic                 busy;

    int total;
    int bad;

    key_sched_ctrl #(.expand_latency_p(L), .num_keys_p(15)) dut (
        .clk_i            (clk),
        .reset_i          (reset),
        .key_i            (key),
        .key_v_i          (key_v),
        .key_ready_o      (key_ready),
        .exp_key_o        (exp_key),
        .exp_round_keys_i (exp_rks),
        .lock_i           (lock),
        .rk_req_v_i       (rk_req_v),
        .rk_idx_i         (rk_idx),
        .rk_v_o           (rk_v),
        .rk_o             (rk),
        .rk_err_o         (rk_err),
        .key_valid_o      (key_valid),
        .busy_o           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in for key_expansion: round keys 0/1 are the key halves, the FIPS-197 key gets its
    // real round keys 2 and 14, everything else is the first half XORed with the index byte.
    function automatic logic [127:0] stub_rk(input logic [0:255] k, input int n);
        logic [7:0]   nb;
        logic [127:0] r;
        nb = n[7:0];
        if (n == 0)                r = k[0:127];
        else if (n == 1)           r = k[128:255];
        else if (k == KF && n == 2)  r = 128'h9ba354118e6925afa51a8b5f2067fcde;
        else if (k == KF && n == 14) r = 128'hfe4890d1e6188d0b046df344706c631e;
        else                       r = k[0:127] ^ {16{nb}};
        return r;
    endfunction

    function automatic logic [0:128*15-1] stub_rks(input logic [0:255] k);
        logic [0:128*15-1] v;
        for (int n = 0; n < 15; n++) v[128*n +: 128] = stub_rk(k, n);
        return v;
    endfunction

    assign exp_rks = stub_rks(exp_key);

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " key_ready"}, 256'(key_ready), 256'(1));
        chk({tag, " exp_key"},   exp_key,         256'(0));
        chk({tag, " key_valid"}, 256'(key_valid), 256'(0));
        chk({tag, " busy"},      256'(busy),      256'(0));
        chk({tag, " rk_v"},      256'(rk_v),      256'(0));
        chk({tag, " rk_err"},    256'(rk_err),    256'(0));
        chk({tag, " rk"},        256'(rk),        256'(0));
    endtask

    // Presents a key for one edge; returns on the falling edge after the handshake edge.
    task automatic load_key(input logic [0:255] k);
        key   = k;
        key_v = 1'b1;
        @(negedge clk);
        key_v = 1'b0;
    endtask

    // Counts cycles from the handshake edge until key_valid_o rises (bounded).
    task automatic wait_valid(input string name);
        int cyc;
        cyc = 0;
        while (!key_valid && cyc < 60) begin
            @(negedge clk);
            cyc++;
        end
        chk({name, " valid latency"}, 256'(cyc), 256'(L));
    endtask

    typedef struct {
        logic         req;
        logic [3:0]   idx;
        logic         v;
        logic         err;
        logic [127:0] rk;
    } vec_t;

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        logic rose;
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        key      = '0;
        key_v    = 1'b0;
        lock     = 1'b0;
        rk_req_v = 1'b0;
        rk_idx   = '0;

        vecs[0] = '{1'b1, 4'd0,  1'b1, 1'b0, 128'h603deb1015ca71be2b73aef0857d7781};
        vecs[1] = '{1'b1, 4'd2,  1'b1, 1'b0, 128'h9ba354118e6925afa51a8b5f2067fcde};
        vecs[2] = '{1'b1, 4'd14, 1'b1, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[3] = '{1'b0, 4'd3,  1'b0, 1'b0, 128'hfe4890d1e6188d0b046df344706c631e};
        vecs[4] = '{1'b1, 4'd15, 1'b0, 1'b1, 128'h0};
        vecs[5] = '{1'b1, 4'd1,  1'b1, 1'b0, 128'h1f352c073b6108d72d9810a30914dff4};
        vecs[6] = '{1'b1, 4'd13, 1'b1, 1'b0, 128'h6d30e61d18c77cb3267ea3fd88707a8c};

        // Reset state
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("reset");

        // 0x64 key: latency, busy window and an out-of-window request
        load_key(K64);
        chk("k64 exp_key", exp_key, K64);
        chk("k64 busy t0", 256'(busy), 256'(1));
        for (int c = 1; c <= L; c++) begin
            rk_req_v = (c == 5);
            rk_idx   = 4'd5;
            @(negedge clk);
            if (c == 5) begin
                chk("expand req err", 256'(rk_err), 256'(1));
                chk("expand req v",   256'(rk_v),   256'(0));
            end
            chk($sformatf("k64 key_valid c%0d", c), 256'(key_valid), 256'(c == L));
            chk($sformatf("k64 busy c%0d", c),      256'(busy),      256'(c < L));
        end
        rk_req_v = 1'b1;
        rk_idx   = 4'd0;
        @(negedge clk);
        rk_req_v = 1'b0;
        chk("k64 rk0", 256'(rk), 256'({16{8'h64}}));
        chk("k64 rk0 v", 256'(rk_v), 256'(1));

        // FIPS-197 key, then the request table
        load_key(KF);
        chk("fips key_valid drop", 256'(key_valid), 256'(0));
        wait_valid("fips");
        for (int i = 0; i < 7; i++) begin
            rk_req_v = vecs[i].req;
            rk_idx   = vecs[i].idx;
            @(negedge clk);
            chk($sformatf("vec%0d v", i),   256'(rk_v),   256'(vecs[i].v));
            chk($sformatf("vec%0d err", i), 256'(rk_err), 256'(vecs[i].err));
            chk($sformatf("vec%0d rk", i),  256'(rk),     256'(vecs[i].rk));
        end
        rk_req_v = 1'b0;

        // Locked READY ignores a presented key
        lock  = 1'b1;
        key   = KL;
        key_v = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("lock ready c%0d", c), 256'(key_ready), 256'(0));
            @(negedge clk);
            chk($sformatf("lock exp_key c%0d", c), exp_key, KF);
            chk($sformatf("lock busy c%0d", c), 256'(busy), 256'(0));
        end
        rk_req_v = 1'b1;
        rk_idx   = 4'd14;
        @(negedge clk);
        rk_req_v = 1'b0;
        chk("lock store rk14", 256'(rk), 256'(128'hfe4890d1e6188d0b046df344706c631e));
        chk("lock store v", 256'(rk_v), 256'(1));
        lock = 1'b0;
        #1;
        chk("unlock ready", 256'(key_ready), 256'(1));
        @(negedge clk);
        key_v = 1'b0;
        chk("unlock exp_key", exp_key, KL);
        chk("unlock busy", 256'(busy), 256'(1));
        chk("unlock key_valid", 256'(key_valid), 256'(0));

        // Reset five cycles into EXPAND, with a request pending on the same edge
        repeat (4) @(negedge clk);
        reset    = 1'b1;
        rk_req_v = 1'b1;
        rk_idx   = 4'd3;
        @(negedge clk);
        reset    = 1'b0;
        rk_req_v = 1'b0;
        chk_reset_vals("midexp");
        rose = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (key_valid || busy) rose = 1'b1;
        end
        chk("midexp no valid", 256'(rose), 256'(0));

        // Simultaneous handshake and request in READY: old store answers
        load_key(KA);
        wait_valid("ka");
        key      = KB;
        key_v    = 1'b1;
        rk_req_v = 1'b1;
        rk_idx   = 4'd14;
        @(negedge clk);
        key_v    = 1'b0;
        rk_req_v = 1'b0;
        chk("simul rk", 256'(rk), 256'({16{8'h0e}}));
        chk("simul v", 256'(rk_v), 256'(1));
        chk("simul key_valid", 256'(key_valid), 256'(0));
        chk("simul exp_key", exp_key, KB);
        wait_valid("kb");
        rk_req_v = 1'b1;
        rk_idx   = 4'd14;
        @(negedge clk);
        rk_req_v = 1'b0;
        chk("kb rk14", 256'(rk), 256'({16{8'hab ^ 8'h0e}}));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
